// File: rtl/ifetch_unit_if.sv
// Instruction memory read bus: request/acknowledge with error.
// Ports: master = fetch side (drives req/addr), slave = memory side (drives ack/rdata/err).
interface ifetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_err;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        input  imem_err
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        output imem_err
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: reads imem at pc, latches the word into ir for decode.
// Ports: clk/rst, pc/flush/pc_wr (PC register side), imem (bus master),
//        ir_valid/ir/ir_pc/ir_ready (decode side), fetch_exc/exc_code.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   pc,
    input  logic          flush,
    output logic          pc_wr,
    ifetch_unit_if.master imem,
    output logic          ir_valid,
    output logic [31:0]   ir,
    output logic [31:0]   ir_pc,
    input  logic          ir_ready,
    output logic          fetch_exc,
    output logic [1:0]    exc_code
);

    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_BUS      = 2'b10;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        EXC
    } state_e;

    state_e        state_q, state_d;
    logic          imem_req_q, imem_req_d;
    logic [31:0]   imem_addr_q, imem_addr_d;
    logic          ir_valid_q, ir_valid_d;
    logic [31:0]   ir_q, ir_d;
    logic [31:0]   ir_pc_q, ir_pc_d;
    logic          fetch_exc_q, fetch_exc_d;
    logic [1:0]    exc_code_q, exc_code_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          discard_q, discard_d;

    logic          drop;
    logic          done;
    logic          timed_out;

    // A flush in the same cycle as the response counts as a discard.
    assign drop      = discard_q | flush;
    assign done      = imem.imem_ack | imem.imem_err;
    assign timed_out = (cnt_q == CNT_MAX);

    assign pc_wr = flush
                 | ((state_q == HOLD) & ir_valid_q & ir_ready);

    always_comb begin
        state_d     = state_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        ir_valid_d  = ir_valid_q;
        ir_d        = ir_q;
        ir_pc_d     = ir_pc_q;
        fetch_exc_d = fetch_exc_q;
        exc_code_d  = exc_code_q;
        cnt_d       = cnt_q;
        discard_d   = discard_q;

        unique case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (pc[1:0] != 2'b00) begin
                    state_d     = EXC;
                    fetch_exc_d = 1'b1;
                    exc_code_d  = EXC_MISALIGN;
                end else begin
                    state_d     = REQ;
                    imem_req_d  = 1'b1;
                    imem_addr_d = pc;
                    cnt_d       = '0;
                end
            end

            REQ: begin
                if (done) begin
                    imem_req_d = 1'b0;
                    discard_d  = 1'b0;
                    if (drop) begin
                        state_d = IDLE;
                    end else if (imem.imem_err) begin
                        state_d     = EXC;
                        fetch_exc_d = 1'b1;
                        exc_code_d  = EXC_BUS;
                    end else begin
                        state_d    = HOLD;
                        ir_valid_d = 1'b1;
                        ir_d       = imem.imem_rdata;
                        ir_pc_d    = imem_addr_q;
                    end
                end else if (timed_out) begin
                    imem_req_d = 1'b0;
                    discard_d  = 1'b0;
                    if (drop) begin
                        state_d = IDLE;
                    end else begin
                        state_d     = EXC;
                        fetch_exc_d = 1'b1;
                        exc_code_d  = EXC_TIMEOUT;
                    end
                end else begin
                    // Below CNT_MAX here, so the increment cannot wrap.
                    cnt_d = cnt_q + 1'b1;
                    if (flush) begin
                        discard_d = 1'b1;
                    end
                end
            end

            HOLD: begin
                if (flush) begin
                    state_d    = IDLE;
                    ir_valid_d = 1'b0;
                    ir_d       = NOP_INSTR;
                end else if (ir_ready) begin
                    state_d    = IDLE;
                    ir_valid_d = 1'b0;
                end
            end

            EXC: begin
                if (flush) begin
                    state_d     = IDLE;
                    fetch_exc_d = 1'b0;
                    exc_code_d  = EXC_NONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            imem_req_q  <= 1'b0;
            imem_addr_q <= 32'h0;
            ir_valid_q  <= 1'b0;
            ir_q        <= NOP_INSTR;
            ir_pc_q     <= RESET_PC;
            fetch_exc_q <= 1'b0;
            exc_code_q  <= EXC_NONE;
            cnt_q       <= '0;
            discard_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            ir_valid_q  <= ir_valid_d;
            ir_q        <= ir_d;
            ir_pc_q     <= ir_pc_d;
            fetch_exc_q <= fetch_exc_d;
            exc_code_q  <= exc_code_d;
            cnt_q       <= cnt_d;
            discard_q   <= discard_d;
        end
    end

    assign imem.imem_req  = imem_req_q;
    assign imem.imem_addr = imem_addr_q;
    assign ir_valid       = ir_valid_q;
    assign ir             = ir_q;
    assign ir_pc          = ir_pc_q;
    assign fetch_exc      = fetch_exc_q;
    assign exc_code       = exc_code_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Testbench for ifetch_unit: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model of the fetch stage.
module tb_ifetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int          TIMEOUT   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic        pc_wr;
    logic        ir_valid;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_ready = 1'b0;
    logic        fetch_exc;
    logic [1:0]  exc_code;

    int n_cmp = 0;
    int n_mis = 0;

    ifetch_unit_if bus ();

    ifetch_unit #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .flush     (flush),
        .pc_wr     (pc_wr),
        .imem      (bus),
        .ir_valid  (ir_valid),
        .ir        (ir),
        .ir_pc     (ir_pc),
        .ir_ready  (ir_ready),
        .fetch_exc (fetch_exc),
        .exc_code  (exc_code)
    );

    always #5 clk = ~clk;

    // Model: an outstanding read (address, cycles waited, dropped?),
    // an instruction waiting for decode, or a pending exception code.
    logic        m_busy;
    logic        m_drop;
    int          m_wait;
    logic [31:0] m_addr;
    logic        m_iv;
    logic [31:0] m_ir;
    logic [31:0] m_irpc;
    logic [1:0]  m_exc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_drop <= 1'b0;
            m_wait <= 0;
            m_addr <= 32'h0;
            m_iv   <= 1'b0;
            m_ir   <= NOP_INSTR;
            m_irpc <= RESET_PC;
            m_exc  <= 2'd0;
            pc     <= RESET_PC;
        end else begin
            if (flush) begin
                pc <= flush_pc;
            end else if (m_iv && ir_ready) begin
                pc <= pc + 32'd4;
            end
            if (m_exc != 2'd0) begin
                if (flush) m_exc <= 2'd0;
            end else if (m_iv) begin
                if (flush || ir_ready) m_iv <= 1'b0;
                if (flush) m_ir <= NOP_INSTR;
            end else if (m_busy) begin
                if (bus.imem_ack || bus.imem_err || (m_wait + 1 == TIMEOUT)) begin
                    m_busy <= 1'b0;
                    m_drop <= 1'b0;
                    if (!(m_drop || flush)) begin
                        if (bus.imem_err) begin
                            m_exc <= 2'd2;
                        end else if (bus.imem_ack) begin
                            m_iv   <= 1'b1;
                            m_ir   <= bus.imem_rdata;
                            m_irpc <= m_addr;
                        end else begin
                            m_exc <= 2'd3;
                        end
                    end
                end else begin
                    m_wait <= m_wait + 1;
                    if (flush) m_drop <= 1'b1;
                end
            end else if (!flush) begin
                if (pc[1:0] != 2'b00) begin
                    m_exc <= 2'd1;
                end else begin
                    m_busy <= 1'b1;
                    m_addr <= pc;
                    m_wait <= 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("pc_wr", 32'(pc_wr), 32'(flush | (m_iv & ir_ready)));
            chk("imem_req", 32'(bus.imem_req), 32'(m_busy));
            chk("imem_addr", bus.imem_addr, m_addr);
            chk("ir_valid", 32'(ir_valid), 32'(m_iv));
            chk("ir", ir, m_ir);
            chk("ir_pc", ir_pc, m_irpc);
            chk("fetch_exc", 32'(fetch_exc), 32'(m_exc != 2'd0));
            chk("exc_code", 32'(exc_code), 32'(m_exc));
        end
    end

    task automatic drive(input logic f, input logic [31:0] t,
                         input logic a, input logic e,
                         input logic [31:0] d, input logic r);
        @(posedge clk);
        #1;
        flush          = f;
        flush_pc       = t;
        bus.imem_ack   = a;
        bus.imem_err   = e;
        bus.imem_rdata = d;
        ir_ready       = r;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"}, 32'(bus.imem_req), 32'h0);
        chk({tag, "_addr"}, bus.imem_addr, 32'h0);
        chk({tag, "_iv"}, 32'(ir_valid), 32'h0);
        chk({tag, "_ir"}, ir, NOP_INSTR);
        chk({tag, "_irpc"}, ir_pc, RESET_PC);
        chk({tag, "_exc"}, 32'(fetch_exc), 32'h0);
        chk({tag, "_code"}, 32'(exc_code), 32'h0);
    endtask

    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_err   = 1'b0;
        bus.imem_rdata = 32'h0;
        #1 rst = 1'b1;
        #12;
        chk_reset_vals("rst0");
        @(negedge clk);
        rst = 1'b0;

        // First fetch, ack in the first REQ cycle, decode ready at once.
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h2008_0005, 1'b0);
        chk("s1_req", 32'(bus.imem_req), 32'h1);
        chk("s1_addr", bus.imem_addr, 32'h0000_3000);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("s1_ir", ir, 32'h2008_0005);
        chk("s1_irpc", ir_pc, 32'h0000_3000);
        chk("s1_iv", 32'(ir_valid), 32'h1);
        chk("s1_pcwr", 32'(pc_wr), 32'h1);
        idle();
        chk("s1_pcwr_off", 32'(pc_wr), 32'h0);
        idle();
        chk("s1_next", bus.imem_addr, 32'h0000_3004);

        // Ack on the fifth REQ cycle, decode stalls three cycles.
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("s2_req", 32'(bus.imem_req), 32'h1);
            chk("s2_addr", bus.imem_addr, 32'h0000_3004);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h00A0_0093, 1'b0);
        chk("s2_req5", 32'(bus.imem_req), 32'h1);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("s2_pcwr0", 32'(pc_wr), 32'h0);
            chk("s2_ir", ir, 32'h00A0_0093);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("s2_pcwr1", 32'(pc_wr), 32'h1);

        // Misaligned PC, then recovery by flush.
        drive(1'b1, 32'h0000_3002, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("s3_pcwr", 32'(pc_wr), 32'h1);
        idle();
        idle();
        chk("s3_exc", 32'(fetch_exc), 32'h1);
        chk("s3_code", 32'(exc_code), 32'h1);
        chk("s3_noreq", 32'(bus.imem_req), 32'h0);
        drive(1'b1, 32'h0000_3008, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("s3_pcwr2", 32'(pc_wr), 32'h1);
        idle();
        chk("s3_clr", 32'(fetch_exc), 32'h0);
        idle();
        chk("s3_addr", bus.imem_addr, 32'h0000_3008);

        // No response: timeout after TIMEOUT request cycles.
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            idle();
            chk("s4_req", 32'(bus.imem_req), 32'h1);
        end
        idle();
        chk("s4_to_exc", 32'(fetch_exc), 32'h1);
        chk("s4_to_code", 32'(exc_code), 32'h3);
        chk("s4_to_req", 32'(bus.imem_req), 32'h0);
        drive(1'b1, 32'h0000_300C, 1'b0, 1'b0, 32'h0, 1'b0);
        idle();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
        idle();
        chk("s4_err_code", 32'(exc_code), 32'h2);
        chk("s4_err_ir", ir, 32'h00A0_0093);
        drive(1'b1, 32'h0000_3010, 1'b0, 1'b0, 32'h0, 1'b0);
        idle();

        // Flush during a request; the late data is dropped.
        drive(1'b1, 32'h0000_3020, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("s5_pcwr", 32'(pc_wr), 32'h1);
        idle();
        chk("s5_addr", bus.imem_addr, 32'h0000_3010);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
        idle();
        chk("s5_iv", 32'(ir_valid), 32'h0);
        chk("s5_ir", ir, 32'h00A0_0093);
        drive(1'b1, 32'h0000_3040, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
        chk("s5_addr2", bus.imem_addr, 32'h0000_3020);
        chk("s5_pcwr2", 32'(pc_wr), 32'h1);
        idle();
        chk("s5_iv2", 32'(ir_valid), 32'h0);
        chk("s5_ir2", ir, 32'h00A0_0093);
        idle();
        chk("s5_addr3", bus.imem_addr, 32'h0000_3040);

        // Asynchronous reset mid-request; an ack right after release is ignored.
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("rst_req");
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        rst = 1'b0;
        idle();
        chk("s6_iv", 32'(ir_valid), 32'h0);
        chk("s6_ir", ir, NOP_INSTR);
        chk("s6_req", 32'(bus.imem_req), 32'h1);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h1111_1111, 1'b0);
        idle();
        chk("s6_hold", ir, 32'h1111_1111);
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("rst_hold");
        @(negedge clk);
        rst = 1'b0;

        // Random traffic, including stalls long enough to time out.
        begin
            int stall = 0;
            for (int i = 0; i < 3000; i++) begin
                logic [31:0] t;
                logic f, a, e, r;
                if (stall > 0) stall--;
                else if ($urandom_range(0, 99) == 0) stall = 20;
                t = $urandom;
                if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
                f = ($urandom_range(0, 11) == 0);
                a = (stall == 0) && ($urandom_range(0, 2) == 0);
                e = (stall == 0) && ($urandom_range(0, 24) == 0);
                r = ($urandom_range(0, 1) == 1);
                drive(f, t, a, e, $urandom, r);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
